// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared types for the AXI3 read arbiter.
// RR_ARB_EN (optional) switches arb_pick to round-robin.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_e;

  localparam int IDW  = 4;
  localparam int LENW = 4;
  localparam int IXW  = 2;

endpackage

// File: rtl/axi_rd_arbiter_pick.sv
// arb_pick: one-hot grant plus index from a request vector.
// RR_ARB_EN rotates the search after last; else lowest index wins.
module arb_pick
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IXW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IXW-1:0]  idx
);

`ifdef RR_ARB_EN
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IXW'(j);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IXW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 AR/R channel among NREQ requesters.
// Define RR_ARB_EN for round-robin, otherwise fixed priority.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int ID_BASE = 0
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*32-1:0] rd_addr,
  input  logic [NREQ*4-1:0]  rd_len,
  output logic [NREQ-1:0]    rd_gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [31:0]        rd_data,
  output logic               rd_last,
  output logic [IDW-1:0]     arid,
  output logic [31:0]        araddr,
  output logic [LENW-1:0]    arlen,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready
);

  state_e          state;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] win_oh;
  logic [IXW-1:0]  pick_idx;
  logic [IXW-1:0]  last;
  logic            ar_hs;

  assign ar_hs = arvalid && arready;

`ifdef RR_ARB_EN
  logic [IXW-1:0] ptr;

  // arid still carries the winner, so the pointer needs no copy of it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= IXW'(NREQ - 1);
    end else if (ar_hs) begin
      ptr <= IXW'(arid - IDW'(ID_BASE));
    end
  end

  assign last = ptr;
`else
  assign last = IXW'(NREQ - 1);
`endif

  arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (rd_req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      win_oh  <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arid    <= IDW'(ID_BASE);
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|rd_req) begin
            win_oh  <= pick_gnt;
            araddr  <= rd_addr[int'(pick_idx)*32 +: 32];
            arlen   <= rd_len[int'(pick_idx)*LENW +: LENW];
            arid    <= IDW'(ID_BASE) + IDW'(pick_idx);
            arvalid <= 1'b1;
            state   <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid && rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_gnt   = ar_hs ? win_oh : '0;
  assign rd_valid = (rready && rvalid) ? win_oh : '0;
  assign rd_data  = rready ? rdata : '0;
  assign rd_last  = rready && rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench with a simple AXI3 read slave.
// Expected bursts are queued as requests are raised.
module tb_axi_rd_arbiter;

  localparam int NREQ = 3;
  localparam int IDB  = 0;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [3:0]  len;
  } exp_t;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic [NREQ-1:0]    rd_req;
  logic [NREQ*32-1:0] rd_addr;
  logic [NREQ*4-1:0]  rd_len;
  logic [NREQ-1:0]    rd_gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [31:0]        rd_data;
  logic               rd_last;
  logic [3:0]         arid;
  logic [31:0]        araddr;
  logic [3:0]         arlen;
  logic               arvalid;
  logic               arready;
  logic [31:0]        rdata;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q[$];

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(
    .NREQ    (NREQ),
    .ID_BASE (IDB)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic raise(int i, logic [31:0] a, logic [3:0] l);
    rd_req[i]         = 1'b1;
    rd_addr[32*i +: 32] = a;
    rd_len[4*i +: 4]  = l;
  endtask

  task automatic push(int i, logic [31:0] a, logic [3:0] l);
    exp_t e;
    e.idx  = i;
    e.addr = a;
    e.len  = l;
    q.push_back(e);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    rd_req  = '0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // gap_exp < 0 skips the AR-latency check; abort_at >= 0 resets mid-burst
  task automatic serve(int ar_wait, bit gaps, bit drop, int gap_exp,
                       int abort_at);
    exp_t        e;
    int          n;
    int          b;
    bit          on;
    logic [31:0] d;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    n = 0;
    while (!arvalid && n < 20) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (!arvalid) begin
      chk("ar_timeout", 0, 1);
      return;
    end
    if (gap_exp >= 0) chk("idle_gap", n, gap_exp);
    chk("arid", arid, IDB + e.idx);
    chk("araddr", araddr, e.addr);
    chk("arlen", arlen, e.len);
    for (int w = 0; w < ar_wait; w++) begin
      arready = 1'b0;
      rvalid  = (w == 1);
      rlast   = (w == 1);
      #1;
      chk("gnt_early", rd_gnt, 0);
      chk("rready_ar", rready, 0);
      chk("rdv_ar", rd_valid, 0);
      @(posedge aclk);
      #1;
      chk("arid_hold", arid, IDB + e.idx);
      chk("araddr_hold", araddr, e.addr);
      chk("arlen_hold", arlen, e.len);
    end
    rvalid  = 1'b0;
    rlast   = 1'b0;
    arready = 1'b1;
    #1;
    chk("gnt", rd_gnt, 1 << e.idx);
    @(posedge aclk);
    #1;
    arready = 1'b0;
    if (drop) rd_req[e.idx] = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("gnt_pulse", rd_gnt, 0);
    b  = 0;
    on = 1'b1;
    n  = 0;
    while (b <= int'(e.len) && n < 64) begin
      if (b == abort_at) begin
        rvalid  = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_arid", arid, IDB);
        chk("rst_gnt", rd_gnt, 0);
        rd_req = '0;
        rvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        return;
      end
      if (gaps && !on) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("rdv_gap", rd_valid, 0);
      end else begin
        d      = e.addr ^ b;
        rvalid = 1'b1;
        rdata  = d;
        rlast  = (b == int'(e.len));
        #1;
        chk("rdv", rd_valid, 1 << e.idx);
        chk("rdata", rd_data, d);
        chk("rlast", rd_last, b == int'(e.len));
        b++;
      end
      on = !on;
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= 64) chk("r_timeout", 0, 1);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = '0;
    chk("rready_idle", rready, 0);
    chk("arvalid_idle", arvalid, 0);
  endtask

  initial begin
    rd_addr = '0;
    rd_len  = '0;
    aresetn = 1'b0;
    rd_req  = '0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    #13;
    chk("rst_arid0", arid, IDB);
    chk("rst_arvalid0", arvalid, 0);
    chk("rst_araddr0", araddr, 0);
    chk("rst_arlen0", arlen, 0);
    chk("rst_rready0", rready, 0);
    chk("rst_gnt0", rd_gnt, 0);
    chk("rst_rdv0", rd_valid, 0);
    chk("rst_rdlast0", rd_last, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // single burst, arready on the 2nd AR cycle
    raise(1, 32'h1FC0_0000, 4'd7);
    push(1, 32'h1FC0_0000, 4'd7);
    serve(1, 1'b0, 1'b1, -1, -1);

    // contention: 0 then 1, one idle cycle between
    raise(0, 32'h8000_0040, 4'd1);
    raise(1, 32'h1FC0_0100, 4'd2);
    push(0, 32'h8000_0040, 4'd1);
    push(1, 32'h1FC0_0100, 4'd2);
    serve(0, 1'b0, 1'b1, -1, -1);
    serve(0, 1'b0, 1'b1, 1, -1);

    // AR backpressure with a stray rvalid
    raise(2, 32'h0000_1230, 4'd2);
    push(2, 32'h0000_1230, 4'd2);
    serve(5, 1'b0, 1'b1, -1, -1);

    // R gaps, rvalid toggling
    raise(0, 32'h0000_5550, 4'd3);
    push(0, 32'h0000_5550, 4'd3);
    serve(0, 1'b1, 1'b1, -1, -1);

    // reset mid-burst, then a clean request
    raise(1, 32'h1FC0_0200, 4'd7);
    push(1, 32'h1FC0_0200, 4'd7);
    serve(0, 1'b0, 1'b1, -1, 2);
    chk("post_rst_arvalid", arvalid, 0);
    raise(2, 32'h0000_7700, 4'd1);
    push(2, 32'h0000_7700, 4'd1);
    serve(0, 1'b0, 1'b1, -1, -1);

    // all three held through six single-beat bursts
    do_reset();
    raise(0, 32'h0000_0A00, 4'd0);
    raise(1, 32'h0000_0B00, 4'd0);
    raise(2, 32'h0000_0C00, 4'd0);
    for (int k = 0; k < 6; k++) begin
`ifdef RR_ARB_EN
      case (k % 3)
        0:       push(0, 32'h0000_0A00, 4'd0);
        1:       push(1, 32'h0000_0B00, 4'd0);
        default: push(2, 32'h0000_0C00, 4'd0);
      endcase
`else
      push(0, 32'h0000_0A00, 4'd0);
`endif
    end
    for (int k = 0; k < 6; k++) begin
      serve(0, 1'b0, 1'b0, (k == 0) ? -1 : 1, -1);
    end
    rd_req = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("final_idle", arvalid, 0);
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI3 read-address/read-data channel between NREQ read requesters. Requester 0 is the dcache refill/uncached load, requester 1 is the icache refill, and requester 2 is spare/uncached fetch.
- Sits between the caches and the top-level AXI pins. It keeps one outstanding read at a time and routes R beats back to the winning requester.
- The write channel is owned by a separate block. arsize/arburst/arlock/arcache/arprot are tied off at the top level.

Parameters:
- NREQ, 3, number of read requesters (2..4)
- ID_BASE, 0, arid = ID_BASE + winner index (4-bit)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- rd_req  in  NREQ  per-requester level request; held with addr/len until its rd_gnt
- rd_addr  in  NREQ*32  request byte address, slice i belongs to requester i
- rd_len  in  NREQ*4  burst beats minus 1 (AXI3 arlen encoding)
- rd_gnt  out  NREQ  one-cycle pulse on the AR handshake of that requester's burst
- rd_valid  out  NREQ  one-hot beat-valid to the current owner
- rd_data  out  32  beat data, shared by all requesters
- rd_last  out  1  final beat, shared by all requesters
- arid  out  4  ID_BASE + winner
- araddr  out  32  latched winner address
- arlen  out  4  latched winner length
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  32  R data
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: all outputs 0 except arid = ID_BASE. The FSM goes to IDLE immediately (asynchronous). An in-flight burst is abandoned, because the slave is reset by the same aresetn.
- FSM states: IDLE, AR, R.
- IDLE:
  - If |rd_req, pick the winner (see arbitration).
  - Latch win, rd_addr[win], rd_len[win]; drive araddr/arlen/arid from the latches; next state AR.
  - arvalid rises on the first AR cycle, i.e. one cycle after the request is seen.
- AR:
  - arvalid=1; araddr/arlen/arid stay stable until arready.
  - Changes on rd_req during AR are ignored.
  - On arvalid&&arready: rd_gnt[win]=1 for that cycle only, arvalid drops next cycle, next state R.
- R:
  - rready=1.
  - rd_valid[win]=rvalid, rd_data=rdata, rd_last=rlast (combinational pass-through, zero latency).
  - On rvalid&&rlast: next state IDLE.
- Outside R: rready=0 and rd_valid=0. rvalid in IDLE/AR is never accepted.
- Throughput: the last R beat is followed by one IDLE cycle, then AR. The minimum gap between bursts is 1 cycle.
- Beat count is not checked; rlast alone terminates the burst.
- A request that drops before its grant is legal only in IDLE. A request seen in IDLE is committed.
- Simultaneous requests: exactly one wins per IDLE cycle. The others keep requesting and are served in later bursts.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined:
  - Round-robin arbitration. A pointer holds the last winner; the search starts at last+1 and wraps at NREQ-1 to 0.
  - The pointer updates on the AR handshake and resets to NREQ-1, so requester 0 wins first.
- Undefined: fixed priority, lowest index wins (dcache over icache).

Decomposition:
- Package axi_rd_arb_pkg holds:
  - state enum {IDLE, AR, R}
  - ID width constant 4
  - LEN width constant 4
- One sub-module, arb_pick: combinational. Takes req vector plus last-winner pointer; outputs a one-hot grant and a binary index. Under RR_ARB_EN it rotates; otherwise it is a priority encoder.

Test Plan:
- Single burst: rd_req=3'b010, addr 0x1FC0_0000, len 7; arready on the 2nd AR cycle -> arid=1, arlen=7, rd_gnt=3'b010 for one cycle, 8 rd_valid[1] beats, rd_last on beat 8, FSM back in IDLE.
- Contention (fixed priority): rd_req=3'b011 held -> requester 0 served first, requester 1 served next, with exactly one IDLE cycle between its rlast and the next arvalid.
- RR_ARB_EN: rd_req=3'b111 held through 6 bursts, each len 0 -> grant order 0,1,2,0,1,2.
- AR backpressure: arready low for 5 cycles -> araddr/arlen/arid stable, no rd_gnt, rready=0; a stray rvalid during AR is not accepted.
- R backpressure/gaps: rvalid toggling 1,0,1,0 for len 3 -> rd_valid pulses only when rvalid=1; rd_last with beat 4.
- Reset mid-burst: aresetn low after 2 of 8 beats -> arvalid/rready/rd_valid go 0 asynchronously; after release a new request starts cleanly with arid=ID_BASE+winner.
